// File: rtl/img_seq_pkg.sv
// Shared types and default frame geometry for the pixel-pair read sequencer.
// Used by the sequencer top, its delay timer and the pixel datapath.
package img_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSYNC = 3'd1,
        ST_HSYNC = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_WIDTH          = 32;
    localparam int DEF_HEIGHT         = 32;
    localparam int DEF_START_UP_DELAY = 100;
    localparam int DEF_HSYNC_DELAY    = 160;
    localparam int DEF_ADDR_W         = 16;

    localparam int TIMER_W = 16;
    localparam int POS_W   = 16;

endpackage

// File: rtl/seq_delay_timer.sv
// Loadable down-counter; tc is high for the single cycle the count sits at 0
// after a load. Loading N produces tc on the (N+1)-th cycle after the load edge.
import img_seq_pkg::*;

module seq_delay_timer #(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;
    logic         active;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - W'(1);
            end
        end
    end

    assign tc = active && (cnt == '0);

endmodule

// File: rtl/image_read_sequencer.sv
// Frame-timing controller issuing pixel-pair read addresses with VSYNC/HSYNC framing.
// Define IMG_SEQ_REPEAT_EN to add the frame_repeat input for back-to-back frames.
import img_seq_pkg::*;

module image_read_sequencer #(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int HEIGHT         = DEF_HEIGHT,
    parameter int START_UP_DELAY = DEF_START_UP_DELAY,
    parameter int HSYNC_DELAY    = DEF_HSYNC_DELAY,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
`ifdef IMG_SEQ_REPEAT_EN
    input  logic              frame_repeat,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic [15:0]       row,
    output logic [15:0]       col,
    output logic              busy,
    output logic              ctrl_done,
    output logic [7:0]        frame_cnt
);

    localparam logic [TIMER_W-1:0] VS_LOAD = TIMER_W'(START_UP_DELAY - 1);
    localparam logic [TIMER_W-1:0] HS_LOAD = TIMER_W'(HSYNC_DELAY - 1);
    localparam logic [POS_W-1:0]   COL_END = POS_W'(WIDTH - 2);
    localparam logic [POS_W-1:0]   ROW_END = POS_W'(HEIGHT - 1);

    state_t               state;
    logic                 tc;
    logic                 load;
    logic [TIMER_W-1:0]   load_val;
    logic                 rep;
    logic                 last_col;
    logic                 last_row;
    logic                 kill;

`ifdef IMG_SEQ_REPEAT_EN
    assign rep = frame_repeat;
`else
    assign rep = 1'b0;
`endif

    assign rd_en    = (state == ST_DATA) && out_ready;
    assign last_col = (col == COL_END);
    assign last_row = (row == ROW_END);
    assign kill     = abort && (state != ST_IDLE);
    assign rd_addr  = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);

    // Timer is (re)loaded on the same edge that enters VSYNC or HSYNC.
    always_comb begin
        load     = 1'b0;
        load_val = VS_LOAD;
        unique case (state)
            ST_IDLE: begin
                load = start;
            end
            ST_VSYNC: begin
                load     = tc;
                load_val = HS_LOAD;
            end
            ST_DATA: begin
                load     = rd_en && last_col && !last_row;
                load_val = HS_LOAD;
            end
            ST_DONE: begin
                load = rep;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    seq_delay_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (HCLK),
        .clear    (HRESET || abort),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            pix_valid <= 1'b0;
            VSYNC     <= 1'b0;
            HSYNC     <= 1'b0;
            busy      <= 1'b0;
            ctrl_done <= 1'b0;
            frame_cnt <= '0;
        end else if (kill) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            pix_valid <= 1'b0;
            VSYNC     <= 1'b0;
            HSYNC     <= 1'b0;
            busy      <= 1'b0;
            ctrl_done <= 1'b0;
        end else begin
            pix_valid <= rd_en;
            ctrl_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state <= ST_VSYNC;
                        VSYNC <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_VSYNC: begin
                    if (tc) begin
                        state <= ST_HSYNC;
                        VSYNC <= 1'b0;
                    end
                end
                ST_HSYNC: begin
                    if (tc) begin
                        state <= ST_DATA;
                        HSYNC <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rd_en) begin
                        if (last_col) begin
                            col   <= '0;
                            HSYNC <= 1'b0;
                            if (last_row) begin
                                row       <= '0;
                                state     <= ST_DONE;
                                ctrl_done <= 1'b1;
                                frame_cnt <= frame_cnt + 8'd1;
                            end else begin
                                row   <= row + 16'd1;
                                state <= ST_HSYNC;
                            end
                        end else begin
                            col <= col + 16'd2;
                        end
                    end
                end
                ST_DONE: begin
                    if (rep) begin
                        state <= ST_VSYNC;
                        VSYNC <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_read_sequencer.sv
// Directed and randomized checks of image_read_sequencer against a timeline model.
// Define IMG_SEQ_REPEAT_EN to also exercise back-to-back frames.
module tb_image_read_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int SU = 3;
    localparam int HS = 2;
    localparam int AW = 16;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b1;
    logic          frame_repeat = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          pix_valid;
    logic          VSYNC;
    logic          HSYNC;
    logic [15:0]   row;
    logic [15:0]   col;
    logic          busy;
    logic          ctrl_done;
    logic [7:0]    frame_cnt;

    always #5 HCLK = ~HCLK;

    image_read_sequencer #(
        .WIDTH          (W),
        .HEIGHT         (H),
        .START_UP_DELAY (SU),
        .HSYNC_DELAY    (HS),
        .ADDR_W         (AW)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .abort     (abort),
        .out_ready (out_ready),
`ifdef IMG_SEQ_REPEAT_EN
        .frame_repeat (frame_repeat),
`endif
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .pix_valid (pix_valid),
        .VSYNC     (VSYNC),
        .HSYNC     (HSYNC),
        .row       (row),
        .col       (col),
        .busy      (busy),
        .ctrl_done (ctrl_done),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        bit rdy, rep, vs, hs, busy, en, done, pv;
        int addr, row, col, fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   fc_model = 0;
    int   fc_end = 0;
    int   done_cycle = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(bit rdy, bit rep, bit vs, bit hs, bit bz,
                                bit en, bit dn, int r, int c, int fc);
        exp_t e;
        e.rdy = rdy; e.rep = rep; e.vs = vs; e.hs = hs; e.busy = bz;
        e.en = en; e.done = dn; e.pv = 1'b0;
        e.row = r; e.col = c; e.addr = r * W + c; e.fcnt = fc;
        return e;
    endfunction

    // Timeline of one or more frames; mode 0 = always ready,
    // 1 = three stall cycles on the pair at address 2, 2 = random stalls.
    function automatic void build(int nframes, int mode);
        int fc = fc_model;
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            bit rep = (f < nframes - 1);
            for (int i = 0; i < SU; i++)
                exp_q.push_back(mk($urandom_range(0, 1) == 1, rep, 1, 0, 1, 0, 0, 0, 0, fc));
            for (int r = 0; r < H; r++) begin
                int c = 0;
                int stalls = 0;
                for (int i = 0; i < HS; i++)
                    exp_q.push_back(mk($urandom_range(0, 1) == 1, rep, 0, 0, 1, 0, 0, r, 0, fc));
                while (c < W) begin
                    bit rd;
                    if (mode == 0) rd = 1'b1;
                    else if (mode == 1) rd = !(r == 0 && c == 2 && stalls < 3);
                    else rd = ($urandom_range(0, 2) != 0);
                    if (!rd) stalls++;
                    exp_q.push_back(mk(rd, rep, 0, 1, 1, rd, 0, r, c, fc));
                    if (rd) c += 2;
                end
            end
            fc = (fc + 1) % 256;
            exp_q.push_back(mk(1, rep, 0, 0, 1, 0, 1, 0, 0, fc));
        end
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, fc));
        for (int k = 1; k < exp_q.size(); k++) exp_q[k].pv = exp_q[k-1].en;
        fc_end = fc;
    endfunction

    task automatic check_entry(input exp_t e, input string t);
        chk({t, "_vsync"},  32'(VSYNC),     32'(e.vs));
        chk({t, "_hsync"},  32'(HSYNC),     32'(e.hs));
        chk({t, "_busy"},   32'(busy),      32'(e.busy));
        chk({t, "_rd_en"},  32'(rd_en),     32'(e.en));
        chk({t, "_pv"},     32'(pix_valid), 32'(e.pv));
        chk({t, "_done"},   32'(ctrl_done), 32'(e.done));
        chk({t, "_addr"},   32'(rd_addr),   32'(e.addr));
        chk({t, "_row"},    32'(row),       32'(e.row));
        chk({t, "_col"},    32'(col),       32'(e.col));
        chk({t, "_fcnt"},   32'(frame_cnt), 32'(e.fcnt));
    endtask

    // Runs the built timeline from a start pulse; stop_k >= 0 injects
    // abort (or HRESET) during that entry and then expects idle.
    task automatic play(input string t, input int stop_k, input bit by_reset, input bit poke);
        exp_t idle;
        done_cycle = -1;
        @(negedge HCLK);
        start = 1'b1;
        abort = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge HCLK);
            start = poke && (k == 5 || k == 8);
            frame_repeat = exp_q[k].rep;
            out_ready = exp_q[k].rdy;
            if (k == stop_k) begin
                if (by_reset) HRESET = 1'b1;
                else abort = 1'b1;
            end
            #1;
            check_entry(exp_q[k], $sformatf("%s_c%0d", t, k + 1));
            if (ctrl_done === 1'b1 && done_cycle < 0) done_cycle = k + 1;
            if (k == stop_k) break;
        end
        if (stop_k >= 0) begin
            if (by_reset) fc_model = 0;
            idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, fc_model);
            @(negedge HCLK);
            HRESET = 1'b0;
            abort = 1'b0;
            out_ready = 1'b1;
            #1;
            check_entry(idle, {t, "_after_stop"});
        end else begin
            fc_model = fc_end;
        end
        start = 1'b0;
    endtask

    initial begin
        exp_t idle;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_entry(idle, "reset");

        build(1, 0);
        play("nominal", -1, 0, 0);
        chk("nominal_done_cycle", 32'(done_cycle), 32'd12);

        build(1, 1);
        play("stall", -1, 0, 0);
        chk("stall_done_cycle", 32'(done_cycle), 32'd15);

        build(1, 0);
        play("start_busy", -1, 0, 1);
        chk("start_busy_done_cycle", 32'(done_cycle), 32'd12);

        build(1, 0);
        play("abort", 9, 0, 0);
        chk("abort_no_done", 32'(done_cycle), 32'hffffffff);

        build(1, 0);
        play("hreset", 3, 1, 0);

        build(1, 0);
        play("post_reset", -1, 0, 0);
        chk("post_reset_done_cycle", 32'(done_cycle), 32'd12);

        for (int i = 0; i < 4; i++) begin
            build(1, 2);
            play($sformatf("rand%0d", i), -1, 0, 0);
        end

`ifdef IMG_SEQ_REPEAT_EN
        build(3, 0);
        play("repeat", -1, 0, 0);
        chk("repeat_first_done", 32'(done_cycle), 32'd12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
